fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; clock port clk, reset port rst_n.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the byte address of the first fetched instruction.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall  input  1  downstream cannot accept; hold the current instruction.
REQ-006 redirect  input  1  branch or jump taken; fetch from redirect_pc.
REQ-007 redirect_pc  input  32  target byte address.
REQ-008 imem_en  output  1  instruction memory read enable.
REQ-009 imem_addr  output  11  instruction memory word address.
REQ-010 imem_dout  input  32  memory read data, valid one cycle after an enabled read.
REQ-011 inst  output  32  fetched instruction to decode.
REQ-012 inst_pc  output  32  byte address of inst.
REQ-013 inst_pc4  output  32  inst_pc + 4.
REQ-014 inst_valid  output  1  inst/inst_pc are a live instruction this cycle.
REQ-015 misalign_err  output  1  sticky flag; a redirect target had bits [1:0] != 0.
REQ-016 inst_count  output  32  count of instructions accepted downstream.

Function
REQ-017 State registers: pc (next fetch address, 32 b), req_pc (address of the in-flight read, 32 b), req_valid (1 b), misalign_err, inst_count.
REQ-018 imem_addr SHALL be combinational: redirect_pc[12:2] when redirect=1, else pc[12:2].
REQ-019 imem_en SHALL be combinational: 0 while rst_n=0; 1 when redirect=1; 0 when stall=1 and redirect=0; 1 otherwise.
REQ-020 Normal cycle (stall=0, redirect=0) SHALL update pc <= pc+4, req_pc <= pc, req_valid <= 1.
REQ-021 Stall cycle (stall=1, redirect=0) SHALL hold pc, req_pc and req_valid; imem_en=0 keeps imem_dout stable, so inst, inst_pc and inst_valid SHALL NOT change.
REQ-022 Redirect cycle SHALL take priority over stall and update pc <= {redirect_pc[31:2],2'b00}+4, req_pc <= {redirect_pc[31:2],2'b00}, req_valid <= 1.
REQ-023 inst SHALL equal imem_dout, inst_pc SHALL equal req_pc, and inst_pc4 SHALL equal req_pc+4, all combinationally.
REQ-024 inst_valid SHALL equal req_valid AND NOT redirect; the redirect cycle kills the wrong-path instruction presented that cycle.
REQ-025 Fetch-to-valid latency SHALL be exactly 1 cycle; the redirect target SHALL appear with inst_valid=1 in the cycle after redirect.
REQ-026 Addition SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 imem_addr SHALL wrap from 2047 to 0 as pc crosses 13-bit boundaries; no error is raised.
REQ-028 misalign_err SHALL be set on any redirect with redirect_pc[1:0] != 0 and cleared only by reset.
REQ-029 inst_count SHALL increment by 1 (modulo 2^32) in every cycle with inst_valid=1 and stall=0.
REQ-030 Redirect with stall=1 SHALL not increment inst_count, because inst_valid=0.

Reset
REQ-031 On rst_n=0, regardless of clk: pc=RESET_PC, req_pc=RESET_PC, req_valid=0, misalign_err=0, inst_count=0; outputs are therefore inst_valid=0, inst_pc=RESET_PC, inst_pc4=RESET_PC+4, imem_en=0.
REQ-032 In the first cycle after rst_n rises: imem_en=1, imem_addr=RESET_PC[12:2]; the next cycle presents inst_valid=1 with inst_pc=RESET_PC.
REQ-033 Reset asserted mid-stream SHALL discard the in-flight fetch; inst_valid=0 immediately.

Verification
REQ-034 Release reset, stall=0, RESET_PC=0 -> imem_addr sequence 0,1,2,3; inst_pc 0,4,8 with inst_valid=1 from the second cycle; inst_count=3 after 4 cycles.
REQ-035 Hold stall=1 for 3 cycles at inst_pc=8 -> imem_en=0; inst, inst_pc=8 and inst_count are unchanged; on release, inst_pc=12 the next cycle.
REQ-036 Assert redirect=1 with redirect_pc=32'h100 while inst_pc=8 -> inst_valid=0 that cycle and imem_addr=64; next cycle inst_pc=32'h100, inst_valid=1, then 32'h104.
REQ-037 Assert redirect and stall together with redirect_pc=32'h203 -> misalign_err=1, fetch from 32'h200 (imem_addr=128), inst_count unchanged; misalign_err stays 1 until reset.
REQ-038 Run with pc=32'h1FFC -> imem_addr 2047 then 0; inst_pc 32'h1FFC then 32'h2000.
REQ-039 Assert rst_n=0 asynchronously mid-stream -> inst_valid=0 and inst_count=0 at once; after release, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: PC sequencing, one-cycle synchronous IMEM read,
// stall hold, redirect with wrong-path kill, misalignment flag and retire counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [10:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        inst_valid,
  output logic        misalign_err,
  output logic [31:0] inst_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;
  logic [31:0] target_pc;

  assign target_pc = {redirect_pc[31:2], 2'b00};

  assign imem_addr  = redirect ? redirect_pc[12:2] : pc_q[12:2];
  // The memory output is only stable across a stall because no read is issued.
  assign imem_en    = rst_n & (redirect | ~stall);
  assign inst       = imem_dout;
  assign inst_pc    = req_pc_q;
  assign inst_pc4   = req_pc_q + 32'd4;
  assign inst_valid = req_valid_q & ~redirect;
  assign misalign_err = misalign_q;
  assign inst_count   = count_q;

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    misalign_d  = misalign_q;
    count_d     = count_q;

    if (redirect) begin
      pc_d        = target_pc + 32'd4;
      req_pc_d    = target_pc;
      req_valid_d = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d        = pc_q + 32'd4;
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
    end

    if (inst_valid && !stall) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      count_q     <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      misalign_q  <= misalign_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a synchronous IMEM model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [10:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        inst_valid;
  logic        misalign_err;
  logic [31:0] inst_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_dout    (imem_dout),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_pc4     (inst_pc4),
    .inst_valid   (inst_valid),
    .misalign_err (misalign_err),
    .inst_count   (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return {16'hC0DE, 5'b0, a};
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) begin
    if (imem_en) imem_dout <= mem_word(imem_addr);
  end

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        en;
    logic [10:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic en, input logic [10:0] addr, input logic v,
                              input logic [31:0] pc, input logic [31:0] cnt,
                              input logic mis);
    vec_t t;
    t.stall = s; t.redirect = r; t.rpc = rpc; t.en = en; t.addr = addr;
    t.valid = v; t.pc = pc; t.cnt = cnt; t.mis = mis;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", i);
    chk({tag, ".imem_en"}, {31'd0, imem_en}, {31'd0, v.en});
    chk({tag, ".imem_addr"}, {21'd0, imem_addr}, {21'd0, v.addr});
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, v.valid});
    chk({tag, ".inst_pc"}, inst_pc, v.pc);
    chk({tag, ".inst_pc4"}, inst_pc4, v.pc + 32'd4);
    chk({tag, ".inst_count"}, inst_count, v.cnt);
    chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, v.mis});
    if (v.valid) chk({tag, ".inst"}, inst, mem_word(v.pc[12:2]));
  endtask

  vec_t vecs[19];

  initial begin
    //             st r  rpc            en addr  v  pc             cnt mis
    vecs[0]  = mk(0, 0, 32'h0,         1, 11'd0,    0, 32'h0,        0, 0);
    vecs[1]  = mk(0, 0, 32'h0,         1, 11'd1,    1, 32'h0,        0, 0);
    vecs[2]  = mk(0, 0, 32'h0,         1, 11'd2,    1, 32'h4,        1, 0);
    vecs[3]  = mk(1, 0, 32'h0,         0, 11'd3,    1, 32'h8,        2, 0);
    vecs[4]  = mk(1, 0, 32'h0,         0, 11'd3,    1, 32'h8,        2, 0);
    vecs[5]  = mk(1, 0, 32'h0,         0, 11'd3,    1, 32'h8,        2, 0);
    vecs[6]  = mk(0, 0, 32'h0,         1, 11'd3,    1, 32'h8,        2, 0);
    vecs[7]  = mk(0, 1, 32'h100,       1, 11'd64,   0, 32'hC,        3, 0);
    vecs[8]  = mk(0, 0, 32'h0,         1, 11'd65,   1, 32'h100,      3, 0);
    vecs[9]  = mk(0, 0, 32'h0,         1, 11'd66,   1, 32'h104,      4, 0);
    vecs[10] = mk(1, 1, 32'h203,       1, 11'd128,  0, 32'h108,      5, 0);
    vecs[11] = mk(1, 0, 32'h0,         0, 11'd129,  1, 32'h200,      5, 1);
    vecs[12] = mk(0, 0, 32'h0,         1, 11'd129,  1, 32'h200,      5, 1);
    vecs[13] = mk(0, 1, 32'h1FFC,      1, 11'd2047, 0, 32'h204,      6, 1);
    vecs[14] = mk(0, 0, 32'h0,         1, 11'd0,    1, 32'h1FFC,     6, 1);
    vecs[15] = mk(0, 0, 32'h0,         1, 11'd1,    1, 32'h2000,     7, 1);
    vecs[16] = mk(0, 1, 32'hFFFF_FFFC, 1, 11'd2047, 0, 32'h2004,     8, 1);
    vecs[17] = mk(0, 0, 32'h0,         1, 11'd0,    1, 32'hFFFF_FFFC, 8, 1);
    vecs[18] = mk(0, 0, 32'h0,         1, 11'd1,    1, 32'h0,        9, 1);

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #12;
    chk("rst.inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.imem_en", {31'd0, imem_en}, 32'd0);
    chk("rst.inst_pc", inst_pc, 32'h0);
    chk("rst.inst_pc4", inst_pc4, 32'h4);
    chk("rst.inst_count", inst_count, 32'd0);
    chk("rst.misalign_err", {31'd0, misalign_err}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      stall = vecs[i].stall;
      redirect = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      #1;
      chk_vec(i, vecs[i]);
      @(negedge clk);
    end
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Asynchronous reset mid-stream, away from any clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst.inst_count", inst_count, 32'd0);
    chk("arst.imem_en", {31'd0, imem_en}, 32'd0);
    chk("arst.misalign_err", {31'd0, misalign_err}, 32'd0);
    chk("arst.inst_pc", inst_pc, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.imem_en", {31'd0, imem_en}, 32'd1);
    chk("rel.imem_addr", {21'd0, imem_addr}, 32'd0);
    chk("rel.inst_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("rel2.inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("rel2.inst_pc", inst_pc, 32'h0);
    chk("rel2.inst", inst, mem_word(11'd0));
    chk("rel2.imem_addr", {21'd0, imem_addr}, 32'd1);
    @(negedge clk);
    #1;
    chk("rel3.inst_pc", inst_pc, 32'h4);
    chk("rel3.inst_count", inst_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
